axis_zero_filler: RTL

AXIS_ZERO_FILLER -- requirements
Module: axis_zero_filler

---
 rtl/axis_zero_filler_pkg.sv | 23 ++
 rtl/axis_zero_filler_fifo.sv | 67 ++++++
 rtl/axis_zero_filler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/axis_zero_filler_pkg.sv
// Shared types and constants for the AXI-Stream zero filler.
// Optional hold-last filler mode is selected by AXIS_ZERO_FILLER_HOLD_EN.
package axis_zero_filler_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    localparam logic FILL_MODE_ZERO = 1'b0;
    localparam logic FILL_MODE_HOLD = 1'b1;

    localparam logic TUSER_FILLER = 1'b1;
    localparam logic TUSER_DATA   = 1'b0;

    // A prime level of zero behaves as one so FILL can always be left.
    function automatic logic prime_met(input logic [31:0] level, input logic [31:0] prime);
        logic [31:0] eff;
        eff = (prime == 32'd0) ? 32'd1 : prime;
        return (level >= eff);
    endfunction

endpackage

// File: rtl/axis_zero_filler_fifo.sv
// Circular word buffer with occupancy count; head word is visible the cycle after it is written.
module axis_zero_filler_fifo
    import axis_zero_filler_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [ADDR_W:0]   o_level,
    output logic              o_full,
    output logic              o_empty
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LVL_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              w_wr;
    logic              w_rd;

    assign w_wr = i_wr_en && (r_level != LVL_FULL);
    assign w_rd = i_rd_en && (r_level != '0);

    // Storage array; contents are don't-care while empty so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;
    assign o_full    = (r_level == LVL_FULL);
    assign o_empty   = (r_level == '0);

endmodule

// File: rtl/axis_zero_filler.sv
// Always-valid AXI-Stream source: buffers input words and emits filler (tuser=1) while priming or starved.
// Define AXIS_ZERO_FILLER_HOLD_EN to add cfg_hold, which repeats the last passed word as filler.
module axis_zero_filler
    import axis_zero_filler_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH_LOG2  = 4,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [FIFO_DEPTH_LOG2:0]    cfg_prime,
`ifdef AXIS_ZERO_FILLER_HOLD_EN
    input  logic                        cfg_hold,
`endif
    output logic [FIFO_DEPTH_LOG2:0]    sts_level,
    output logic [CNTR_WIDTH-1:0]       sts_underruns,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tuser
);

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);
    localparam logic [CNTR_WIDTH-1:0] CNT_MAX = '1;

    state_t                      r_state;
    logic [CNTR_WIDTH-1:0]       r_underruns;
    logic [AXIS_TDATA_WIDTH-1:0] w_head;
    logic [FIFO_DEPTH_LOG2:0]    w_level;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_prime_met;
    logic [AXIS_TDATA_WIDTH-1:0] w_filler;
    logic [AXIS_TDATA_WIDTH-1:0] w_out_data;
    logic                        w_out_user;

    assign s_axis_tready = ~areset & ~w_full;
    assign w_push        = s_axis_tvalid & s_axis_tready;
    assign w_pop         = (r_state == ST_PASS) & ~w_empty & m_axis_tready;
    assign w_prime_met   = prime_met(32'(w_level), 32'(cfg_prime));

    axis_zero_filler_fifo #(
        .DATA_W (AXIS_TDATA_WIDTH),
        .ADDR_W (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .i_clk     (aclk),
        .i_rst     (areset),
        .i_wr_en   (w_push),
        .i_wr_data (s_axis_tdata),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_level   (w_level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Mode FSM and saturating underrun counter; cfg_prime is only sampled in FILL.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= ST_FILL;
            r_underruns <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_prime_met) begin
                        r_state <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (w_empty && m_axis_tready) begin
                        r_state <= ST_FILL;
                        if (r_underruns != CNT_MAX) begin
                            r_underruns <= r_underruns + CNT_ONE;
                        end
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

`ifdef AXIS_ZERO_FILLER_HOLD_EN
    logic [AXIS_TDATA_WIDTH-1:0] r_last;
    logic                        w_fill_mode;

    // Remembers the most recent word handed downstream in PASS.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_last <= '0;
        end else if (w_pop) begin
            r_last <= w_head;
        end
    end

    assign w_fill_mode = cfg_hold ? FILL_MODE_HOLD : FILL_MODE_ZERO;
    assign w_filler    = (w_fill_mode == FILL_MODE_HOLD) ? r_last : '0;
`else
    assign w_filler    = '0;
`endif

    // Head word only when passing with data available; everything else is filler.
    always_comb begin
        w_out_data = w_filler;
        w_out_user = TUSER_FILLER;
        if ((r_state == ST_PASS) && !w_empty) begin
            w_out_data = w_head;
            w_out_user = TUSER_DATA;
        end else begin
            w_out_data = w_filler;
            w_out_user = TUSER_FILLER;
        end
    end

    assign m_axis_tdata  = w_out_data;
    assign m_axis_tuser  = w_out_user;
    assign m_axis_tvalid = ~areset;
    assign sts_level     = w_level;
    assign sts_underruns = r_underruns;

endmodule
